dcache_lsu: RTL and testbench
=============================

// Module: dcache_lsu
// PURPOSE
//  Load/store unit between the MEM pipeline stage and the Dcache pipeline interface. Accepts one memory op
//  per valid/ready handshake and checks alignment. Holds a stable request on the Dcache port until hit/write
//  completion. Extracts and sign/zero-extends load data, returns a tagged response, and counts loads,
//  stores and miss-stall cycles.
// PARAMETERS
//  ADDR_WIDTH  64  byte address width
//  DATA_WIDTH  64  Dcache word width (8 bytes)
//  TAG_WIDTH    5  destination-register tag carried request->response
//  CNT_WIDTH   32  performance counter width (saturating)
// PORTS
//  clk            in   1            clock, rising edge
//  reset_n        in   1            asynchronous, active-low reset
//  req_valid      in   1            MEM stage presents an op
//  req_ready      out  1            LSU accepts op this cycle
//  req_wrn        in   1            1=store, 0=load
//  req_addr       in   ADDR_WIDTH   byte address
//  req_wdata      in   DATA_WIDTH   store data, right-justified
//  req_size       in   2            access = 2^req_size bytes
//  req_unsigned   in   1            load: zero-extend (1) / sign-extend (0)
//  req_tag        in   TAG_WIDTH    destination tag
//  resp_valid     out  1            response available
//  resp_ready     in   1            consumer takes response
//  resp_data      out  DATA_WIDTH   extended load data; 0 for stores/faults
//  resp_tag       out  TAG_WIDTH    tag of completed op
//  resp_store     out  1            completed op was a store
//  resp_fault     out  1            misaligned access, no cache access made
//  dc_addr        out  64           Dcache addr
//  dc_wdata       out  64           Dcache wdata
//  dc_wlen        out  2            Dcache wlen
//  dc_enable      out  1            Dcache request strobe
//  dc_wrn         out  1            Dcache write/read
//  dc_rdata       in   64           Dcache word at dc_addr (whole aligned word)
//  dc_valid       in   1            Dcache read hit this cycle
//  dc_write_done  in   1            Dcache write hit/committed this cycle
//  cnt_loads/cnt_stores/cnt_stall  out  CNT_WIDTH  completed loads, completed stores, cycles in BUSY without done
// BEHAVIOUR
//  States:
//   IDLE  req_ready=1. On req_valid, latch all req_* fields.
//         Misaligned (addr mod 2^size != 0): go to RESP with fault=1.
//         Otherwise: go to BUSY.
//   BUSY  dc_enable=1; dc_addr/wdata/wlen/wrn driven only from latched registers, stable throughout.
//         Load: dc_valid=1 -> capture extended data, go to RESP.
//         Store: dc_write_done=1 -> go to RESP.
//         Otherwise stay; cnt_stall++.
//   RESP  resp_valid=1. When resp_ready=1: go to IDLE, counters update (no count on fault).
//  Outputs:
//   - req_ready=(state==IDLE); resp_* registered, driven only in RESP.
//   - No new request is accepted in the cycle that RESP retires; 1 op in flight max.
//  Latency:
//   - Hit load/store: accept @T, dc_enable @T+1, resp_valid @T+2.
//   - Miss: resp_valid at the cycle after done + 1.
//  Load extract: off=addr[2:0].
//   - size0: rdata[8*off+:8]
//   - size1: rdata[16*off[2:1]+:16]
//   - size2: rdata[32*off[2]+:32]
//   - size3: full word
//   - Extend to 64 by req_unsigned.
//  Store: dc_wdata=latched req_wdata unshifted; the Dcache positions it by addr.
//  Boundaries:
//   - dc_valid/dc_write_done are ignored outside BUSY.
//   - Counters saturate at all-ones.
//   - Async reset mid-BUSY: dc_enable drops immediately; state=IDLE.
//   - The Dcache's own reset is driven from the same source at top level.
//  Reset values:
//   - state=IDLE; req_ready=1.
//   - resp_valid/resp_store/resp_fault=0; resp_data/resp_tag=0.
//   - dc_enable=0; dc_wrn=0; dc_addr/dc_wdata/dc_wlen=0.
//   - All counters=0.
// STRUCTURE
//  Shared package: lsu_state_e {IDLE,BUSY,RESP}, SIZE_B/H/W/D=0..3 constants, function is_misaligned().
//  One sub-module: lsu_load_align (combinational extract + extend: rdata, off, size, unsigned -> data).
// TESTING
//  - Load byte @0x1003, size0, signed, rdata=0x0000_0000_8000_0000, dc_valid @T+1 -> resp_data=0xFFFF_FFFF_FFFF_FF80 @T+2, cnt_loads=1.
//  - Same load unsigned -> resp_data=0x80. Word load @0x1004 of 0x8765_4321_0000_0000 signed -> 0xFFFF_FFFF_8765_4321.
//  - Store size2 @0x2004, dc_write_done held low 20 cycles -> dc_addr/wdata stable 20 cycles, cnt_stall=20, resp_store=1 after done.
//  - Half load @0x3001 -> resp_fault=1 @T+1, dc_enable never asserted, counters unchanged.
//  - resp_ready low 5 cycles in RESP -> resp held stable, req_ready=0; reset_n pulsed mid-BUSY -> dc_enable=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/dcache_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dcache_lsu_pkg
// Shared types and helpers for the load/store unit:
//   lsu_state_e      control FSM states (IDLE / BUSY / RESP)
//   SIZE_B..SIZE_D   access size encodings (2^size bytes)
//   CNT_*            indices of the performance counters
//   is_misaligned()  natural-alignment check for an access
// -----------------------------------------------------------------------------
package dcache_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam int CNT_LOAD  = 0;
  localparam int CNT_STORE = 1;
  localparam int CNT_STALL = 2;
  localparam int CNT_NUM   = 3;

  // An access of 2^size bytes is legal only if the low 'size' address bits are zero.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational extraction of a load result from a whole aligned Dcache word,
// followed by sign or zero extension to 64 bits.
// Ports:
//   rdata        in  64  aligned Dcache word
//   off          in   3  byte offset of the access inside the word
//   size         in   2  access size, 2^size bytes
//   is_unsigned  in   1  1 = zero-extend, 0 = sign-extend
//   data         out 64  extended load value
// -----------------------------------------------------------------------------
module lsu_load_align
  import dcache_lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  logic [7:0]  b_lane [8];
  logic [15:0] h_lane [4];
  logic [31:0] w_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign b_lane[gi] = rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_half
      assign h_lane[gi] = rdata[16*gi +: 16];
    end
    for (gi = 0; gi < 2; gi++) begin : g_word
      assign w_lane[gi] = rdata[32*gi +: 32];
    end
  endgenerate

  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] w_sel;

  always_comb begin
    b_sel = b_lane[off];
    h_sel = h_lane[off[2:1]];
    w_sel = w_lane[off[2]];
    data  = rdata;
    case (size)
      SIZE_B:  data = is_unsigned ? {56'b0, b_sel} : {{56{b_sel[7]}}, b_sel};
      SIZE_H:  data = is_unsigned ? {48'b0, h_sel} : {{48{h_sel[15]}}, h_sel};
      SIZE_W:  data = is_unsigned ? {32'b0, w_sel} : {{32{w_sel[31]}}, w_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dcache_lsu.sv
// -----------------------------------------------------------------------------
// dcache_lsu
// Load/store unit between the MEM stage and the Dcache pipeline port.
// One op in flight: accepted in IDLE, issued to the Dcache in BUSY, returned
// in RESP. Misaligned ops skip the cache and return a fault.
// Ports:
//   clk, reset_n                 clock / asynchronous active-low reset
//   req_valid/req_ready          request handshake from MEM
//   req_wrn, req_addr, req_wdata, req_size, req_unsigned, req_tag   request fields
//   resp_valid/resp_ready        response handshake
//   resp_data, resp_tag, resp_store, resp_fault                      response fields
//   dc_addr, dc_wdata, dc_wlen, dc_enable, dc_wrn                    Dcache request
//   dc_rdata, dc_valid, dc_write_done                                Dcache completion
//   cnt_loads, cnt_stores, cnt_stall                                 saturating counters
// The Dcache is reset from the same reset_n source at top level, so both sides
// come out of reset together.
// DATA_WIDTH is expected to be 64 (the load aligner works on 8-byte words).
// -----------------------------------------------------------------------------
module dcache_lsu
  import dcache_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wrn,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_store,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [DATA_WIDTH-1:0] dc_wdata,
  output logic [1:0]            dc_wlen,
  output logic                  dc_enable,
  output logic                  dc_wrn,
  input  logic [DATA_WIDTH-1:0] dc_rdata,
  input  logic                  dc_valid,
  input  logic                  dc_write_done,
  output logic [CNT_WIDTH-1:0]  cnt_loads,
  output logic [CNT_WIDTH-1:0]  cnt_stores,
  output logic [CNT_WIDTH-1:0]  cnt_stall
);

  lsu_state_e state_reg, state_next;

  // Latched request; these registers alone drive the Dcache port so it stays
  // stable for the whole BUSY period regardless of what MEM does.
  logic                  wrn_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [1:0]            size_reg;
  logic                  uns_reg;
  logic [TAG_WIDTH-1:0]  tag_reg;
  logic                  fault_reg;
  logic [DATA_WIDTH-1:0] load_data_reg;

  logic                  accept;
  logic                  misaligned;
  logic                  busy_done;
  logic                  retire;
  logic [DATA_WIDTH-1:0] load_ext;

  assign accept     = (state_reg == IDLE) && req_valid;
  assign misaligned = is_misaligned(req_addr[2:0], req_size);
  // Completion strobes only mean something while BUSY; elsewhere they are ignored.
  assign busy_done  = (state_reg == BUSY) && (wrn_reg ? dc_write_done : dc_valid);
  assign retire     = (state_reg == RESP) && resp_ready;

  lsu_load_align u_load_align (
    .rdata       (dc_rdata),
    .off         (addr_reg[2:0]),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .data        (load_ext)
  );

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------- FSM next
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = misaligned ? RESP : BUSY;
      BUSY:    if (busy_done) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  // Response fields are forced to zero outside RESP so the consumer never sees
  // stale data from a previous op.
  always_comb begin
    req_ready  = (state_reg == IDLE);
    dc_enable  = (state_reg == BUSY);
    resp_valid = (state_reg == RESP);
    resp_data  = '0;
    resp_tag   = '0;
    resp_store = 1'b0;
    resp_fault = 1'b0;
    if (state_reg == RESP) begin
      resp_data  = load_data_reg;
      resp_tag   = tag_reg;
      resp_store = wrn_reg;
      resp_fault = fault_reg;
    end
    dc_addr  = addr_reg;
    dc_wdata = wdata_reg;
    dc_wlen  = size_reg;
    dc_wrn   = wrn_reg;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrn_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      size_reg      <= '0;
      uns_reg       <= 1'b0;
      tag_reg       <= '0;
      fault_reg     <= 1'b0;
      load_data_reg <= '0;
    end else if (accept) begin
      wrn_reg       <= req_wrn;
      addr_reg      <= req_addr;
      wdata_reg     <= req_wdata;
      size_reg      <= req_size;
      uns_reg       <= req_unsigned;
      tag_reg       <= req_tag;
      fault_reg     <= misaligned;
      // Stores and faults report zero data; a load overwrites this on hit.
      load_data_reg <= '0;
    end else if (busy_done && !wrn_reg) begin
      load_data_reg <= load_ext;
    end
  end

  // ---------------------------------------------------------------- counters
  logic [CNT_NUM-1:0]   cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_vec [CNT_NUM];

  assign cnt_inc[CNT_LOAD]  = retire && !fault_reg && !wrn_reg;
  assign cnt_inc[CNT_STORE] = retire && !fault_reg &&  wrn_reg;
  assign cnt_inc[CNT_STALL] = (state_reg == BUSY) && !busy_done;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] count_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != '1)) begin
          count_reg <= count_reg + CNT_WIDTH'(1);
        end
      end
      assign cnt_vec[gi] = count_reg;
    end
  endgenerate

  assign cnt_loads  = cnt_vec[CNT_LOAD];
  assign cnt_stores = cnt_vec[CNT_STORE];
  assign cnt_stall  = cnt_vec[CNT_STALL];

endmodule

// File: tb/tb_dcache_lsu.sv
// -----------------------------------------------------------------------------
// tb_dcache_lsu
// Directed stimulus for dcache_lsu with a response scoreboard: each issued op
// pushes its expected response; a monitor pops and compares on every
// resp_valid && resp_ready.
// -----------------------------------------------------------------------------
module tb_dcache_lsu;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wrn;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_store;
  logic        resp_fault;
  logic [63:0] dc_addr;
  logic [63:0] dc_wdata;
  logic [1:0]  dc_wlen;
  logic        dc_enable;
  logic        dc_wrn;
  logic [63:0] dc_rdata;
  logic        dc_valid;
  logic        dc_write_done;
  logic [31:0] cnt_loads;
  logic [31:0] cnt_stores;
  logic [31:0] cnt_stall;

  dcache_lsu dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wrn       (req_wrn),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_tag       (req_tag),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_tag      (resp_tag),
    .resp_store    (resp_store),
    .resp_fault    (resp_fault),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .dc_wlen       (dc_wlen),
    .dc_enable     (dc_enable),
    .dc_wrn        (dc_wrn),
    .dc_rdata      (dc_rdata),
    .dc_valid      (dc_valid),
    .dc_write_done (dc_write_done),
    .cnt_loads     (cnt_loads),
    .cnt_stores    (cnt_stores),
    .cnt_stall     (cnt_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        store;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_loads  = 0;
  int   exp_stores = 0;
  int   exp_stall  = 0;

  localparam logic [63:0] IDLE_RDATA = 64'hA5A5_A5A5_A5A5_A5A5;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got tag %0d, expected no response", resp_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("resp tag=%0d data=0x%016h store=%0b fault=%0b", resp_tag, resp_data, resp_store, resp_fault);
        check("resp_data",  resp_data,        e.data);
        check("resp_tag",   64'(resp_tag),    64'(e.tag));
        check("resp_store", 64'(resp_store),  64'(e.store));
        check("resp_fault", 64'(resp_fault),  64'(e.fault));
      end
    end
  end

  task automatic check_counters(input string name);
    check({name, "_cnt_loads"},  64'(cnt_loads),  64'(exp_loads));
    check({name, "_cnt_stores"}, 64'(cnt_stores), 64'(exp_stores));
    check({name, "_cnt_stall"},  64'(cnt_stall),  64'(exp_stall));
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
  task automatic do_op(input string name, input logic wrn, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [4:0] tag, input logic [63:0] rdata, input int delay,
                       input logic [63:0] exp_data, input logic exp_fault, input int hold);
    exp_t e;
    e.data = exp_data; e.tag = tag; e.store = wrn; e.fault = exp_fault;
    exp_q.push_back(e);
    resp_ready   = (hold == 0);
    req_valid    = 1'b1;
    req_wrn      = wrn;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_tag      = tag;
    @(negedge clk);
    check({name, "_req_ready"}, 64'(req_ready), 64'd1);
    check({name, "_dc_enable_idle"}, 64'(dc_enable), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 64'hFFFF_0000_FFFF_0000;
    req_wdata = 64'h0123_4567_89AB_CDEF;
    if (!exp_fault) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check({name, "_stall_dc_enable"}, 64'(dc_enable), 64'd1);
        check({name, "_stall_dc_addr"},   dc_addr,  addr);
        check({name, "_stall_dc_wdata"},  dc_wdata, wdata);
        @(posedge clk); #1;
      end
      if (wrn) dc_write_done = 1'b1;
      else begin
        dc_valid = 1'b1;
        dc_rdata = rdata;
      end
      @(negedge clk);
      check({name, "_dc_enable"}, 64'(dc_enable), 64'd1);
      check({name, "_dc_addr"},   dc_addr, addr);
      check({name, "_dc_wlen"},   64'(dc_wlen), 64'(size));
      check({name, "_dc_wrn"},    64'(dc_wrn), 64'(wrn));
      @(posedge clk); #1;
      dc_valid      = 1'b0;
      dc_write_done = 1'b0;
      dc_rdata      = IDLE_RDATA;
    end
    @(negedge clk);
    check({name, "_resp_valid"}, 64'(resp_valid), 64'd1);
    if (exp_fault) check({name, "_fault_dc_enable"}, 64'(dc_enable), 64'd0);
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_hold_resp_valid"}, 64'(resp_valid), 64'd1);
      check({name, "_hold_resp_data"},  resp_data, exp_data);
      check({name, "_hold_resp_tag"},   64'(resp_tag), 64'(tag));
      check({name, "_hold_req_ready"},  64'(req_ready), 64'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (!exp_fault) begin
      if (wrn) exp_stores++;
      else exp_loads++;
      exp_stall += delay;
    end
    @(negedge clk);
    check({name, "_back_idle"}, 64'(req_ready), 64'd1);
    check({name, "_resp_dropped"}, 64'(resp_valid), 64'd0);
    check_counters(name);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_wrn       = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_size      = '0;
    req_unsigned  = 1'b0;
    req_tag       = '0;
    resp_ready    = 1'b1;
    dc_rdata      = IDLE_RDATA;
    dc_valid      = 1'b0;
    dc_write_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  64'(req_ready),  64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_dc_enable",  64'(dc_enable),  64'd0);
    check("rst_dc_addr",    dc_addr, 64'd0);
    check_counters("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Completion strobes outside BUSY must be ignored
    dc_valid = 1'b1; dc_write_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ignore_resp_valid", 64'(resp_valid), 64'd0);
      check("ignore_req_ready",  64'(req_ready),  64'd1);
      @(posedge clk); #1;
    end
    dc_valid = 1'b0; dc_write_done = 1'b0;
    @(negedge clk);
    check_counters("ignore");
    @(posedge clk); #1;

    //     name      wrn  addr          wdata                  sz    uns   tag    rdata                  dly  exp_data                fault hold
    do_op("lb_s",    0, 64'h1003, 64'h0,                 2'd0, 1'b0, 5'd1, 64'h0000_0000_8000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0);
    do_op("lbu",     0, 64'h1003, 64'h0,                 2'd0, 1'b1, 5'd2, 64'h0000_0000_8000_0000, 0, 64'h0000_0000_0000_0080, 1'b0, 0);
    do_op("lw_s",    0, 64'h1004, 64'h0,                 2'd2, 1'b0, 5'd3, 64'h8765_4321_0000_0000, 0, 64'hFFFF_FFFF_8765_4321, 1'b0, 0);
    do_op("lhu_m",   0, 64'h1006, 64'h0,                 2'd1, 1'b1, 5'd4, 64'h1234_5678_9ABC_DEF0, 3, 64'h0000_0000_0000_1234, 1'b0, 0);
    do_op("ld",      0, 64'h1008, 64'h0,                 2'd3, 1'b0, 5'd5, 64'hFEDC_BA98_7654_3210, 0, 64'hFEDC_BA98_7654_3210, 1'b0, 0);
    do_op("lb_pos",  0, 64'h1005, 64'h0,                 2'd0, 1'b0, 5'd6, 64'h0000_7F00_0000_0000, 0, 64'h0000_0000_0000_007F, 1'b0, 0);
    do_op("sw_miss", 1, 64'h2004, 64'h0000_0000_DEAD_BEEF, 2'd2, 1'b0, 5'd7, 64'h0,               20, 64'h0,                  1'b0, 0);
    do_op("lh_mis",  0, 64'h3001, 64'h0,                 2'd1, 1'b0, 5'd8, 64'h0,                  0, 64'h0,                  1'b1, 0);
    do_op("lh_hold", 0, 64'h1002, 64'h0,                 2'd1, 1'b0, 5'd9, 64'h0000_0000_8001_0000, 0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 5);

    // Asynchronous reset in the middle of a miss
    req_valid = 1'b1; req_wrn = 1'b0; req_addr = 64'h5000; req_size = 2'd3;
    req_unsigned = 1'b0; req_tag = 5'd10; req_wdata = 64'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_busy_dc_enable", 64'(dc_enable), 64'd1);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    check("rstmid_dc_enable",  64'(dc_enable),  64'd0);
    check("rstmid_req_ready",  64'(req_ready),  64'd1);
    check("rstmid_resp_valid", 64'(resp_valid), 64'd0);
    check("rstmid_dc_addr",    dc_addr, 64'd0);
    check("rstmid_dc_wlen",    64'(dc_wlen), 64'd0);
    check("rstmid_resp_tag",   64'(resp_tag), 64'd0);
    exp_loads = 0; exp_stores = 0; exp_stall = 0;
    check_counters("rstmid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op("post_rst", 0, 64'h1000, 64'h0, 2'd1, 1'b1, 5'd11, 64'h0000_0000_0000_BEEF, 1, 64'h0000_0000_0000_BEEF, 1'b0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
